// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory stage: request/ack data-memory port, load extension, error detection
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        done,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err,
  output logic [1:0]  err_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    lat_off;
  logic [2:0]    lat_f3;
  logic [4:0]    lat_rd;
  logic          lat_load;

  logic          req_illegal;
  logic          req_misaligned;
  logic          timeout_hit;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  always_comb begin
    req_illegal = (is_load == is_store)
               || (is_load && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
               || (is_store && funct3 > 3'b010);
`ifdef LSU_MISALIGN_TRAP_EN
    req_misaligned = (funct3[1:0] == 2'b01 && addr[0])
                  || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
    req_misaligned = 1'b0;
`endif
  end

  // Store lane placement; sub-word data is replicated across every lane.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[{lat_off, 3'b000} +: 8];
    half_sel = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_f3)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT > 0) && ((32'(wait_cnt) + 32'd1) == 32'(TIMEOUT));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = (req_illegal || req_misaligned) ? RESP : BUSY;
      BUSY: if (mem_ack || timeout_hit) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  assign req_ready = (state == IDLE);
  assign done      = (state == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      lat_off   <= 2'b00;
      lat_f3    <= 3'b000;
      lat_rd    <= 5'd0;
      lat_load  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
      err       <= 1'b0;
      err_cause <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'b0000;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          lat_off  <= addr[1:0];
          lat_f3   <= funct3;
          lat_rd   <= rd;
          lat_load <= is_load;
          wait_cnt <= '0;
          if (req_illegal) begin
            err       <= 1'b1;
            err_cause <= 2'b11;
          end else if (req_misaligned) begin
            err       <= 1'b1;
            err_cause <= 2'b01;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= is_store;
            mem_addr <= {addr[31:2], 2'b00};
            mem_be   <= is_store ? be_calc : 4'b1111;
            if (is_store) mem_wdata <= wdata_calc;
          end
        end
        BUSY: begin
          // Ack has priority over a timeout landing on the same edge.
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            err       <= 1'b0;
            err_cause <= 2'b00;
            if (lat_load) begin
              wb_rd    <= lat_rd;
              wb_data  <= load_ext;
              wb_valid <= (lat_rd != 5'd0);
            end
          end else if (timeout_hit) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            err       <= 1'b1;
            err_cause <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          err      <= 1'b0;
          wb_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit (TIMEOUT=4)
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, store_data = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        done, wb_valid, err, mem_req, mem_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, mem_addr, mem_wdata;
  logic [1:0]  err_cause;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .rd(rd), .done(done), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .err(err), .err_cause(err_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, data;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          ack;
    int          lat;
    logic        err;
    logic [1:0]  cause;
    logic        wbv;
    logic [31:0] wbd;
    logic [3:0]  be;
    logic [31:0] wdata;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                              input logic [31:0] rdat, input int ack, input int lat, input logic e,
                              input logic [1:0] c, input logic wbv, input logic [31:0] wbd,
                              input logic [3:0] be, input logic [31:0] wd);
    vec_t v;
    v.name = nm; v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.data = d; v.rd = r;
    v.rdata = rdat; v.ack = ack; v.lat = lat; v.err = e; v.cause = c; v.wbv = wbv;
    v.wbd = wbd; v.be = be; v.wdata = wd;
    return v;
  endfunction

  // Reference model: outcome of one access from the architectural rules (TIMEOUT=4).
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int size, base;
    bit illegal, mis;
    logic [63:0] raw, span;
    illegal = (v.ld == v.st) || (v.ld && (v.f3 == 3 || v.f3 == 6 || v.f3 == 7)) || (v.st && v.f3 > 2);
    size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (v.addr % size) != 0;
`endif
    r.err = 1'b0; r.cause = 2'd0; r.wbv = 1'b0; r.wbd = 32'd0; r.be = 4'hF; r.wdata = v.data;
    if (illegal) begin
      r.err = 1'b1; r.cause = 2'd3; r.lat = 0;
    end else if (mis) begin
      r.err = 1'b1; r.cause = 2'd1; r.lat = 0;
    end else begin
      base = ((v.addr % 4) / size) * size;
      if (v.st) begin
        r.be = 4'h0;
        for (int j = 0; j < 4; j++) begin
          r.be[j] = (j >= base) && (j < base + size);
          r.wdata[8*j +: 8] = v.data[8*(j % size) +: 8];
        end
      end
      if (v.ack > 4) begin
        r.lat = 4; r.err = 1'b1; r.cause = 2'd2;
      end else begin
        r.lat = v.ack;
        if (v.ld && v.rd != 0) begin
          r.wbv = 1'b1;
          span = 64'd1 << (8 * size);
          raw = (64'(v.rdata) >> (8 * base)) % span;
          if (!v.f3[2] && size < 4 && raw >= (span >> 1)) raw = raw - span;
          r.wbd = raw[31:0];
        end
      end
    end
    return r;
  endfunction

  task automatic run(input vec_t v);
    int          done_at, reqcnt, unstable, w;
    bit          seen;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_we, req_at_done;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    check({v.name, " ready"}, 32'(req_ready), 32'd1);
    is_load = v.ld; is_store = v.st; funct3 = v.f3; addr = v.addr;
    store_data = v.data; rd = v.rd; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; addr = $urandom();
    done_at = -1; reqcnt = 0; unstable = 0; seen = 1'b0; req_at_done = 1'b1;
    m_addr = 32'd0; m_wdata = 32'd0; m_be = 4'd0; m_we = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        done_at = k;
        req_at_done = mem_req;
        break;
      end
      if (mem_req) begin
        if (!seen) begin
          m_addr = mem_addr; m_wdata = mem_wdata; m_be = mem_be; m_we = mem_we;
        end else if (mem_addr !== m_addr || mem_wdata !== m_wdata || mem_be !== m_be || mem_we !== m_we) begin
          unstable++;
        end
        seen = 1'b1;
        reqcnt++;
      end
      mem_ack = (k + 1 == v.ack);
      mem_rdata = mem_ack ? v.rdata : $urandom();
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check({v.name, " latency"}, 32'(done_at), 32'(v.lat));
    check({v.name, " req_cycles"}, 32'(reqcnt), 32'(v.lat));
    check({v.name, " req_at_done"}, 32'(req_at_done), 32'd0);
    check({v.name, " err"}, 32'(err), 32'(v.err));
    if (v.err) check({v.name, " err_cause"}, 32'(err_cause), 32'(v.cause));
    check({v.name, " wb_valid"}, 32'(wb_valid), 32'(v.wbv));
    if (v.wbv) begin
      check({v.name, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
      check({v.name, " wb_data"}, wb_data, v.wbd);
    end
    if (v.lat > 0) begin
      check({v.name, " mem_addr"}, m_addr, v.addr & ~32'h3);
      check({v.name, " mem_we"}, 32'(m_we), 32'(v.st));
      check({v.name, " mem_be"}, 32'(m_be), 32'(v.be));
      if (v.st) check({v.name, " mem_wdata"}, m_wdata, v.wdata);
      check({v.name, " stable"}, 32'(unstable), 32'd0);
    end
    @(negedge clk);
    check({v.name, " done_pulse"}, {30'd0, done, req_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    int   sel;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst done", 32'(done), 32'd0);
    check("rst wb_valid", 32'(wb_valid), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst wb_rd", 32'(wb_rd), 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    check("rst err_cause", 32'(err_cause), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst mem_be", 32'(mem_be), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    vq.push_back(mk("sw",        0,1,3'd2,32'h100,32'hDEADBEEF,5'd0,32'h0,       3, 3,0,2'd0,0,32'h0,       4'hF,32'hDEADBEEF));
    vq.push_back(mk("lb",        1,0,3'd0,32'h103,32'h0,       5'd5,32'h80FF0000,1, 1,0,2'd0,1,32'hFFFFFF80,4'hF,32'h0));
    vq.push_back(mk("lhu",       1,0,3'd5,32'h102,32'h0,       5'd7,32'h80011234,2, 2,0,2'd0,1,32'h00008001,4'hF,32'h0));
    vq.push_back(mk("lh",        1,0,3'd1,32'h102,32'h0,       5'd7,32'h80011234,2, 2,0,2'd0,1,32'hFFFF8001,4'hF,32'h0));
    vq.push_back(mk("lw_rd0",    1,0,3'd2,32'h100,32'h0,       5'd0,32'hCAFEF00D,1, 1,0,2'd0,0,32'h0,       4'hF,32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
    vq.push_back(mk("lw_mis",    1,0,3'd2,32'h101,32'h0,       5'd3,32'h12345678,1, 0,1,2'd1,0,32'h0,       4'hF,32'h0));
    vq.push_back(mk("sh_odd",    0,1,3'd1,32'h301,32'h12345678,5'd0,32'h0,       1, 0,1,2'd1,0,32'h0,       4'hF,32'h0));
`else
    vq.push_back(mk("lw_mis",    1,0,3'd2,32'h101,32'h0,       5'd3,32'h12345678,1, 1,0,2'd0,1,32'h12345678,4'hF,32'h0));
    vq.push_back(mk("sh_odd",    0,1,3'd1,32'h301,32'h12345678,5'd0,32'h0,       1, 1,0,2'd0,0,32'h0,       4'h3,32'h56785678));
`endif
    vq.push_back(mk("lw_tmo",    1,0,3'd2,32'h200,32'h0,       5'd9,32'h0,       6, 4,1,2'd2,0,32'h0,       4'hF,32'h0));
    vq.push_back(mk("sw_ack4",   0,1,3'd2,32'h204,32'h0BADF00D,5'd0,32'h0,       4, 4,0,2'd0,0,32'h0,       4'hF,32'h0BADF00D));
    vq.push_back(mk("ill_both",  1,1,3'd2,32'h0,  32'h0,       5'd1,32'h0,       1, 0,1,2'd3,0,32'h0,       4'hF,32'h0));
    vq.push_back(mk("ill_st_f3", 0,1,3'd4,32'h0,  32'h0,       5'd1,32'h0,       1, 0,1,2'd3,0,32'h0,       4'hF,32'h0));
    vq.push_back(mk("ill_ld_f3", 1,0,3'd3,32'h0,  32'h0,       5'd1,32'h0,       1, 0,1,2'd3,0,32'h0,       4'hF,32'h0));
    vq.push_back(mk("ill_none",  0,0,3'd0,32'h0,  32'h0,       5'd1,32'h0,       1, 0,1,2'd3,0,32'h0,       4'hF,32'h0));
    vq.push_back(mk("sb",        0,1,3'd0,32'h302,32'h000000A5,5'd0,32'h0,       1, 1,0,2'd0,0,32'h0,       4'h4,32'hA5A5A5A5));
    vq.push_back(mk("sh",        0,1,3'd1,32'h302,32'hBEEF1234,5'd0,32'h0,       1, 1,0,2'd0,0,32'h0,       4'hC,32'h12341234));
    vq.push_back(mk("lbu",       1,0,3'd4,32'h101,32'h0,       5'd4,32'h0000C300,1, 1,0,2'd0,1,32'h000000C3,4'hF,32'h0));

    foreach (vq[i]) run(vq[i]);

    // Randomized accesses against the reference model
    for (int n = 0; n < 60; n++) begin
      v.name = $sformatf("rnd%0d", n);
      sel = $urandom_range(0, 9);
      v.ld = (sel == 1) || (sel >= 2 && sel <= 5);
      v.st = (sel == 1) || (sel >= 6);
      v.f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (v.ld && !v.st) v.f3 = (($urandom_range(0, 4) < 3) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5)));
        else if (v.st && !v.ld) v.f3 = 3'($urandom_range(0, 2));
      end
      v.addr = $urandom(); v.data = $urandom(); v.rdata = $urandom();
      v.rd = 5'($urandom_range(0, 31)); v.ack = $urandom_range(1, 6);
      run(model(v));
    end

    // Reset asserted two cycles into BUSY, then a stray ack
    @(negedge clk);
    is_load = 1'b1; funct3 = 3'd2; addr = 32'h40; rd = 5'd2; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; is_load = 1'b0;
    @(negedge clk); @(negedge clk);
    check("midrst busy mem_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst mem_req", 32'(mem_req), 32'd0);
    check("midrst req_ready", 32'(req_ready), 32'd1);
    check("midrst done", 32'(done), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stray_ack c%0d", c), {29'd0, done, mem_req, req_ready}, 32'd1);
      @(negedge clk);
    end
    run(mk("post_rst_lw", 1,0,3'd2,32'h44,32'h0,5'd6,32'h01020304,2, 2,0,2'd0,1,32'h01020304,4'hF,32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage of the RV32I core, directly downstream of `arithmetic_logic_unit`. It takes the ALU-computed effective address plus `src2_value` for loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) and runs a request/acknowledge transaction on a 32-bit word-addressed data-memory port. It then hands the sign- or zero-extended load result to register-file writeback. Misalignment, illegal encodings and memory timeouts are detected here.

## Interface
- `TIMEOUT`, default 255: maximum cycles waiting for `mem_ack`; 0 disables the timeout.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state when 0.
- `req_valid`  in  1  execute stage presents an access.
- `req_ready`  out  1  unit idle, can accept.
- `is_load`, `is_store`  in  1 each  access kind.
- `funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  effective address (ALU result).
- `store_data`  in  32  `src2_value`.
- `rd`  in  5  load destination register.
- `done`  out  1  one-cycle completion pulse (load, store or error).
- `wb_valid`  out  1  writeback strobe; load success and `rd`≠0 only.
- `wb_rd`  out  5  writeback register.
- `wb_data`  out  32  extended load data.
- `err`  out  1  with `done`: access failed.
- `err_cause`  out  2  01 misaligned, 10 timeout, 11 illegal.
- `mem_req`, `mem_we`  out  1 each  memory request, write enable.
- `mem_addr`  out  32  word address, bits [1:0] always 00.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables; loads drive 1111.
- `mem_ack`  in  1  memory completes the request on this edge.
- `mem_rdata`  in  32  read word, valid with `mem_ack`.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE: `req_ready`=1. Acceptance occurs when `req_valid`=1 at a rising edge.
- Illegal request: `is_load`==`is_store`, load `funct3` in {011,110,111}, or store `funct3`>010.
  - Transition to RESP with `err_cause`=11. No memory access.
- Misaligned request (with macro): H with `addr[0]`=1, or W with `addr[1:0]`≠00.
  - Transition to RESP with `err_cause`=01. No memory access.
- Otherwise: latch `addr[1:0]`, `funct3`, `rd`, kind. Drive the memory outputs and go to BUSY.
- Store lanes:
  - B: `mem_be`=0001<<`addr[1:0]`, `mem_wdata`={4{data[7:0]}}.
  - H: `mem_be`=`addr[1]`?1100:0011, `mem_wdata`={2{data[15:0]}}.
  - W: `mem_be`=1111, `mem_wdata`=data.
- BUSY: `mem_req` and all `mem_*` outputs are held stable until `mem_ack` is sampled high.
  - Ack: capture and extract the selected byte/half. Sign-extend for B/H, zero-extend for BU/HU. Go to RESP.
  - A wait counter increments on each BUSY edge without ack. When it reaches `TIMEOUT` (`TIMEOUT`>0), drop `mem_req` and go to RESP with `err_cause`=10.
  - Ack and timeout on the same edge: ack wins.
- RESP: `done`=1 for exactly one cycle. `wb_valid` follows the rule in Interface. `err` is set for any error. Return to IDLE.
- `mem_ack` in IDLE or RESP is ignored.

## Timing
- Reset values: `done`, `wb_valid`, `err`, `mem_req`, `mem_we`=0. `req_ready`=1. `wb_rd`, `wb_data`, `err_cause`, `mem_addr`, `mem_wdata`, `mem_be`, wait counter=0.
- All outputs are registered or decoded from state. No combinational path from `mem_ack` to `mem_req`.
- Accept on edge N: `mem_req`=1 from N.
- Ack sampled on edge N+k (k≥1): `done` is high from N+k to N+k+1.
- Minimum load-use latency: 2 edges. Error requests: `done` after 1 edge.
- Throughput: at most one access per 3 cycles. `req_ready`=0 in BUSY and RESP.
- `wb_*` and `err_cause` are valid only while `done`=1. They keep their last values otherwise.
- Reset asserted mid-operation: immediately IDLE, `mem_req`=0, pending access dropped, no `done`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned accesses complete with `err_cause`=01 and never reach memory.
- Not defined: no misalignment check. H ignores `addr[0]`; W ignores `addr[1:0]`. The access proceeds on the aligned word, and cause 01 is never produced.

## Test plan
- SW `addr`=0x100, data=0xDEADBEEF, ack after 3 cycles -> `mem_addr`=0x100, `mem_be`=1111, `mem_wdata`=0xDEADBEEF, `mem_we`=1 held 3 cycles; `done`=1, `wb_valid`=0.
- LB `addr`=0x103, `rd`=5, `mem_rdata`=0x80FF0000, immediate ack -> `wb_valid`=1, `wb_rd`=5, `wb_data`=0xFFFFFF80, 2 edges after accept.
- LHU `addr`=0x102, `mem_rdata`=0x80011234 -> `wb_data`=0x00008001. Same read with LH -> 0xFFFF8001. LW with `rd`=0 -> `done`=1, `wb_valid`=0.
- LW `addr`=0x101 -> with macro: `err_cause`=01, `mem_req` never rises. Without macro: `mem_addr`=0x100, normal completion.
- `TIMEOUT`=4, never ack -> `mem_req` high exactly 4 cycles, then `done`=1, `err`=1, `err_cause`=10. Ack on the 4th edge instead -> normal completion.
- Reset pulled low 2 cycles into BUSY -> `mem_req`=0 immediately, `req_ready`=1, no `done`. A stray `mem_ack` after reset is ignored.
